// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared constants for the lab CPU control unit.
// Holds the controller state encodings, the opcode/op encodings of the
// instruction set, the write-back source (vsel) encodings, the one-hot
// register-select (nsel) codes, and helpers giving the state that follows
// DECODE and GET_B for a given opcode/op pair.
package cpu_ctrl_pkg;

    // Controller states
    localparam logic [3:0] S_WAIT      = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_WRITE_IMM = 4'd2;
    localparam logic [3:0] S_GET_A     = 4'd3;
    localparam logic [3:0] S_GET_B     = 4'd4;
    localparam logic [3:0] S_ALU_EXE   = 4'd5;
    localparam logic [3:0] S_MOV_EXE   = 4'd6;
    localparam logic [3:0] S_CMP_EXE   = 4'd7;
    localparam logic [3:0] S_WRITE_REG = 4'd8;

    // Opcodes and op sub-codes
    localparam logic [2:0] OPC_MOV     = 3'b110;
    localparam logic [2:0] OPC_ALU     = 3'b101;
    localparam logic [1:0] OP_ADD      = 2'b00;
    localparam logic [1:0] OP_CMP      = 2'b01;
    localparam logic [1:0] OP_AND      = 2'b10;
    localparam logic [1:0] OP_MVN      = 2'b11;
    localparam logic [1:0] OP_MOV_REG  = 2'b00;
    localparam logic [1:0] OP_MOV_IMM  = 2'b10;

    // Write-back source select
    localparam logic [1:0] VSEL_C      = 2'b00;
    localparam logic [1:0] VSEL_IMM8   = 2'b01;

    // One-hot register-file address select; NONE falls back to Rm
    localparam logic [2:0] NSEL_NONE   = 3'b000;
    localparam logic [2:0] NSEL_RM     = 3'b001;
    localparam logic [2:0] NSEL_RD     = 3'b010;
    localparam logic [2:0] NSEL_RN     = 3'b100;

    // State entered after DECODE; unknown encodings go straight back to WAIT.
    function automatic logic [3:0] decode_next(input logic [2:0] opcode,
                                               input logic [1:0] op);
        logic [3:0] nxt;
        nxt = S_WAIT;
        if (opcode == OPC_MOV && op == OP_MOV_IMM)      nxt = S_WRITE_IMM;
        else if (opcode == OPC_MOV && op == OP_MOV_REG) nxt = S_GET_B;
        else if (opcode == OPC_ALU && op == OP_MVN)     nxt = S_GET_B;
        else if (opcode == OPC_ALU)                     nxt = S_GET_A;
        return nxt;
    endfunction

    // State entered after GET_B.
    function automatic logic [3:0] get_b_next(input logic [2:0] opcode,
                                              input logic [1:0] op);
        logic [3:0] nxt;
        nxt = S_ALU_EXE;
        if (opcode == OPC_MOV && op == OP_MOV_REG)  nxt = S_MOV_EXE;
        else if (opcode == OPC_ALU && op == OP_CMP) nxt = S_CMP_EXE;
        return nxt;
    endfunction

endpackage

// File: rtl/cpu_controller_instr_dec.sv
// instr_dec: purely combinational instruction field decoder.
// Ports:
//   ir        in   instruction register contents
//   nsel      in   one-hot register select (Rn/Rd/Rm, none = Rm)
//   opcode    out  IR[15:13]
//   op        out  IR[12:11]
//   shift     out  IR[4:3]
//   aluop     out  op for ALU instructions, ADD for everything else
//   sximm8    out  sign-extended IR[7:0]
//   sximm5    out  sign-extended IR[4:0]
//   readnum   out  register-file read address selected by nsel
//   writenum  out  register-file write address (same as readnum)
module instr_dec
    import cpu_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] ir,
    input  logic [2:0]       nsel,
    output logic [2:0]       opcode,
    output logic [1:0]       op,
    output logic [1:0]       shift,
    output logic [1:0]       aluop,
    output logic [WIDTH-1:0] sximm8,
    output logic [WIDTH-1:0] sximm5,
    output logic [2:0]       readnum,
    output logic [2:0]       writenum
);

    logic [2:0] rn;
    logic [2:0] rd;
    logic [2:0] rm;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign shift  = ir[4:3];
    assign rm     = ir[2:0];

    assign sximm8 = {{(WIDTH-8){ir[7]}}, ir[7:0]};
    assign sximm5 = {{(WIDTH-5){ir[4]}}, ir[4:0]};

    // MOV uses the adder with A forced to 0, so it always gets ADD.
    assign aluop = (opcode == OPC_ALU) ? op : OP_ADD;

    always_comb begin
        readnum = rm;
        case (nsel)
            NSEL_RN: readnum = rn;
            NSEL_RD: readnum = rd;
            default: readnum = rm;
        endcase
    end

    assign writenum = readnum;

endmodule

// File: rtl/cpu_controller.sv
// cpu_controller: multi-cycle control unit for the lab CPU datapath.
// Holds the instruction register, sequences one instruction per start pulse
// and drives the datapath strobes as Moore functions of state and IR.
// Ports:
//   clk, reset            clock; synchronous active-low reset
//   s, load, in           start, IR load enable, instruction word
//   readnum, writenum     register-file addresses
//   shift, ALUop          shifter and ALU operation
//   sximm8, sximm5        sign-extended immediates
//   vsel                  write-back source select
//   loada/b/c, loads      datapath register enables
//   asel, bsel            operand selects
//   write                 register-file write enable
//   w                     high while idle in WAIT
//   state_dbg             current FSM state (for checkers)
//
// Handshake: the controller is ready exactly when w==1. An edge with w==1
// and load==1 copies in into IR; an edge with w==1 and s==1 starts the
// instruction held in IR (including a word loaded on that same edge).
// load and s are ignored while busy (w==0).
module cpu_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s,
    input  logic             load,
    input  logic [WIDTH-1:0] in,
    output logic [2:0]       readnum,
    output logic [2:0]       writenum,
    output logic [1:0]       shift,
    output logic [1:0]       ALUop,
    output logic [WIDTH-1:0] sximm8,
    output logic [WIDTH-1:0] sximm5,
    output logic [1:0]       vsel,
    output logic             loada,
    output logic             loadb,
    output logic             loadc,
    output logic             loads,
    output logic             asel,
    output logic             bsel,
    output logic             write,
    output logic             w,
    output logic [3:0]       state_dbg
);

    logic [3:0]       state;
    logic [WIDTH-1:0] ir;
    logic [2:0]       nsel;
    logic [2:0]       opcode;
    logic [1:0]       op;

    instr_dec #(.WIDTH(WIDTH)) u_dec (
        .ir       (ir),
        .nsel     (nsel),
        .opcode   (opcode),
        .op       (op),
        .shift    (shift),
        .aluop    (ALUop),
        .sximm8   (sximm8),
        .sximm5   (sximm5),
        .readnum  (readnum),
        .writenum (writenum)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_WAIT;
            ir    <= '0;
        end else begin
            // IR only changes while idle so a running instruction is never corrupted.
            if (load && state == S_WAIT)
                ir <= in;
            case (state)
                S_WAIT:      if (s) state <= S_DECODE;
                S_DECODE:    state <= decode_next(opcode, op);
                S_WRITE_IMM: state <= S_WAIT;
                S_GET_A:     state <= S_GET_B;
                S_GET_B:     state <= get_b_next(opcode, op);
                S_ALU_EXE:   state <= S_WRITE_REG;
                S_MOV_EXE:   state <= S_WRITE_REG;
                S_CMP_EXE:   state <= S_WAIT;
                S_WRITE_REG: state <= S_WAIT;
                default:     state <= S_WAIT;
            endcase
        end
    end

    always_comb begin
        nsel  = NSEL_NONE;
        vsel  = VSEL_C;
        loada = 1'b0;
        loadb = 1'b0;
        loadc = 1'b0;
        loads = 1'b0;
        asel  = 1'b0;
        bsel  = 1'b0;
        write = 1'b0;
        w     = 1'b0;
        case (state)
            S_WAIT:      w = 1'b1;
            S_WRITE_IMM: begin nsel = NSEL_RN; vsel = VSEL_IMM8; write = 1'b1; end
            S_GET_A:     begin nsel = NSEL_RN; loada = 1'b1; end
            S_GET_B:     begin nsel = NSEL_RM; loadb = 1'b1; end
            S_ALU_EXE:   loadc = 1'b1;
            // MOV reg passes B through the adder with A forced to zero.
            S_MOV_EXE:   begin loadc = 1'b1; asel = 1'b1; end
            S_CMP_EXE:   loads = 1'b1;
            S_WRITE_REG: begin nsel = NSEL_RD; vsel = VSEL_C; write = 1'b1; end
            default:     ;
        endcase
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_cpu_controller.sv
module tb_cpu_controller;
    import cpu_ctrl_pkg::*;

    localparam int WIDTH = 16;

    // clock / reset
    logic clk = 1'b0;
    logic reset;
    logic s;
    logic load;
    logic [WIDTH-1:0] in_word;

    always #5 clk = ~clk;

    logic [2:0]       readnum, writenum;
    logic [1:0]       shift, aluop, vsel;
    logic [WIDTH-1:0] sximm8, sximm5;
    logic             loada, loadb, loadc, loads, asel, bsel, write, w;
    logic [3:0]       state_dbg;

    cpu_controller #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .s         (s),
        .load      (load),
        .in        (in_word),
        .readnum   (readnum),
        .writenum  (writenum),
        .shift     (shift),
        .ALUop     (aluop),
        .sximm8    (sximm8),
        .sximm5    (sximm5),
        .vsel      (vsel),
        .loada     (loada),
        .loadb     (loadb),
        .loadc     (loadc),
        .loads     (loads),
        .asel      (asel),
        .bsel      (bsel),
        .write     (write),
        .w         (w),
        .state_dbg (state_dbg)
    );

    // scoreboard counters
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // per-instruction trace
    int         lat, nw, na, nb, nc, ns, nbsel;
    logic [2:0] wr_num, ra, rb;
    logic [1:0] wr_vsel, c_aluop;
    logic       c_asel;
    logic [15:0] wr_imm;

    task automatic clear_trace();
        lat = 0; nw = 0; na = 0; nb = 0; nc = 0; ns = 0; nbsel = 0;
        wr_num = '0; ra = '0; rb = '0; wr_vsel = '0; c_aluop = '0; c_asel = 1'b0; wr_imm = '0;
    endtask

    task automatic sample();
        if (write) begin nw++; wr_num = writenum; wr_vsel = vsel; wr_imm = sximm8; end
        if (loada) begin na++; ra = readnum; end
        if (loadb) begin nb++; rb = readnum; end
        if (loadc) begin nc++; c_asel = asel; c_aluop = aluop; end
        if (loads) ns++;
        if (bsel) nbsel++;
    endtask

    // driver: load + start on one edge, then run until w returns (bounded)
    task automatic run_instr(input logic [15:0] word, input logic busy_load, input logic hold_s);
        clear_trace();
        in_word = word;
        load = 1'b1;
        s = 1'b1;
        tick();
        lat = 1;
        s = hold_s;
        load = busy_load;
        if (busy_load) in_word = 16'hD2FF;
        while (w !== 1'b1 && lat < 20) begin
            sample();
            tick();
            lat++;
        end
        load = 1'b0;
    endtask

    task automatic expect_trace(input string tag, input int e_lat, input int e_nw,
                                input logic [2:0] e_wr, input logic [1:0] e_vsel,
                                input int e_na, input logic [2:0] e_ra,
                                input int e_nb, input logic [2:0] e_rb,
                                input int e_nc, input logic e_asel, input logic [1:0] e_alu,
                                input int e_ns);
        check({tag, "_latency"}, lat, e_lat);
        check({tag, "_w_back"}, w, 1'b1);
        check({tag, "_nwrite"}, nw, e_nw);
        check({tag, "_nloada"}, na, e_na);
        check({tag, "_nloadb"}, nb, e_nb);
        check({tag, "_nloadc"}, nc, e_nc);
        check({tag, "_nloads"}, ns, e_ns);
        check({tag, "_nbsel"}, nbsel, 0);
        if (e_nw > 0) begin
            check({tag, "_writenum"}, wr_num, e_wr);
            check({tag, "_vsel"}, wr_vsel, e_vsel);
        end
        if (e_na > 0) check({tag, "_ra"}, ra, e_ra);
        if (e_nb > 0) check({tag, "_rb"}, rb, e_rb);
        if (e_nc > 0) begin
            check({tag, "_asel"}, c_asel, e_asel);
            check({tag, "_aluop"}, c_alu_get(), e_alu);
        end
    endtask

    function automatic logic [1:0] c_alu_get();
        return c_aluop;
    endfunction

    initial begin
        int k;
        reset = 1'b0; s = 1'b0; load = 1'b0; in_word = '0;
        tick();
        reset = 1'b1;
        check("rst_w", w, 1'b1);
        check("rst_write", write, 1'b0);
        check("rst_loads", loads, 1'b0);
        check("rst_strobes", {loada, loadb, loadc, asel, bsel}, 5'b0);
        check("rst_vsel", vsel, 2'b00);
        check("rst_state", state_dbg, S_WAIT);
        check("rst_ir_sximm8", sximm8, 16'h0000);
        for (int i = 0; i < 5; i++) tick();
        check("idle_state", state_dbg, S_WAIT);
        check("idle_w", w, 1'b1);

        // MOV R2,#4
        run_instr(16'hD204, 1'b0, 1'b0);
        expect_trace("mov_imm", 3, 1, 3'd2, 2'b01, 0, 3'd0, 0, 3'd0, 0, 1'b0, 2'b00, 0);
        check("mov_imm_sximm8", wr_imm, 16'h0004);
        // MOV R2,#-1
        run_instr(16'hD2FF, 1'b0, 1'b0);
        expect_trace("mov_neg", 3, 1, 3'd2, 2'b01, 0, 3'd0, 0, 3'd0, 0, 1'b0, 2'b00, 0);
        check("mov_neg_sximm8", wr_imm, 16'hFFFF);
        // ADD R3,R0,R3,LSL#1
        run_instr(16'hA06B, 1'b0, 1'b0);
        expect_trace("add", 6, 1, 3'd3, 2'b00, 1, 3'd0, 1, 3'd3, 1, 1'b0, 2'b00, 0);
        check("add_shift", shift, 2'b01);
        check("add_idle_readnum_rm", readnum, 3'd3);
        check("add_sximm5", sximm5, 16'h000B);
        // CMP R1,R3
        run_instr(16'hA903, 1'b0, 1'b0);
        expect_trace("cmp", 5, 0, 3'd0, 2'b00, 1, 3'd1, 1, 3'd3, 0, 1'b0, 2'b00, 1);
        // MVN R2,R3
        run_instr(16'hBB43, 1'b0, 1'b0);
        expect_trace("mvn", 5, 1, 3'd2, 2'b00, 0, 3'd0, 1, 3'd3, 1, 1'b0, 2'b11, 0);
        // AND R4,R1,R2
        run_instr(16'hB182, 1'b0, 1'b0);
        expect_trace("and", 6, 1, 3'd4, 2'b00, 1, 3'd1, 1, 3'd2, 1, 1'b0, 2'b10, 0);
        // MOV R5,R2
        run_instr(16'hC0A2, 1'b0, 1'b0);
        expect_trace("mov_reg", 5, 1, 3'd5, 2'b00, 0, 3'd0, 1, 3'd2, 1, 1'b1, 2'b00, 0);
        // illegal encoding
        run_instr(16'hE000, 1'b0, 1'b0);
        expect_trace("illegal", 2, 0, 3'd0, 2'b00, 0, 3'd0, 0, 3'd0, 0, 1'b0, 2'b00, 0);

        // load while busy must not disturb IR
        run_instr(16'hA06B, 1'b1, 1'b0);
        expect_trace("busy_load", 6, 1, 3'd3, 2'b00, 1, 3'd0, 1, 3'd3, 1, 1'b0, 2'b00, 0);
        check("busy_load_ir", sximm8, 16'h006B);

        // s held high: w high exactly one cycle then the next instruction starts
        run_instr(16'hD204, 1'b0, 1'b1);
        check("b2b_latency", lat, 3);
        tick();
        check("b2b_w_drop", w, 1'b0);
        check("b2b_state", state_dbg, S_DECODE);
        s = 1'b0;
        clear_trace();
        k = 0;
        while (w !== 1'b1 && k < 20) begin sample(); tick(); k++; end
        check("b2b_second_nwrite", nw, 1);
        check("b2b_second_lat", k, 2);

        // reset during GET_B of ADD
        in_word = 16'hA06B; load = 1'b1; s = 1'b1;
        tick();
        load = 1'b0; s = 1'b0;
        k = 1;
        while (state_dbg !== S_GET_B && k < 10) begin tick(); k++; end
        check("rst_mid_getb", state_dbg, S_GET_B);
        check("rst_mid_loadb", loadb, 1'b1);
        reset = 1'b0;
        tick();
        check("rst_mid_state", state_dbg, S_WAIT);
        check("rst_mid_w", w, 1'b1);
        check("rst_mid_ir", sximm8, 16'h0000);
        reset = 1'b1;
        clear_trace();
        for (int i = 0; i < 6; i++) begin sample(); tick(); end
        check("rst_mid_nwrite", nw, 0);
        check("rst_mid_nloadc", nc, 0);
        check("rst_mid_idle", state_dbg, S_WAIT);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
Multi-cycle control unit for the lab CPU datapath (8-entry register file, A/B/C pipeline registers, shifter, ALU, status register).
- Holds the instruction register and decodes its fields.
- Sequences one instruction per start pulse by driving the datapath load/select/write strobes.
- Raises w when idle.
- Sits between the top-level cpu wrapper and the datapath; replaces any ad hoc sequencing in the wrapper.

Parameters:
WIDTH, 16, datapath and instruction width.

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-low reset (reset==0 at a rising edge resets)
s  in  1  start: begin executing IR contents
load  in  1  latch in into IR
in  in  WIDTH  instruction word
readnum  out  3  register-file read address
writenum  out  3  register-file write address (equals readnum)
shift  out  2  shifter op, IR[4:3]
ALUop  out  2  ALU op
sximm8  out  WIDTH  sign-extended IR[7:0]
sximm5  out  WIDTH  sign-extended IR[4:0]
vsel  out  2  write-back source: 00=C, 01=sximm8, 10/11 reserved (drive 00)
loada, loadb, loadc, loads  out  1 each  register enables for A, B, C, status
asel  out  1  1 = A operand forced to 0
bsel  out  1  1 = B operand is sximm5 (always 0 in this instruction set)
write  out  1  register-file write enable
w  out  1  1 only in WAIT state

Behaviour:
- Reset (reset==0 at edge): state=WAIT, IR=0. Cycle after: w=1; all strobes (loada/b/c, loads, write)=0; asel=bsel=0; vsel=00.
- IR: loads in at an edge where load==1 and state==WAIT. Otherwise load is ignored, so an in-flight instruction cannot be corrupted.
- load and s high on the same edge: IR takes the new word and the new word executes.
- Decode fields: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], Rm=IR[2:0].
- Internal nsel (one-hot Rn/Rd/Rm) drives readnum=writenum; Rm when no nsel is active.
- ALUop = op for opcode 101, 2'b00 (ADD) for opcode 110.
- All control outputs are Moore functions of state plus IR.
- Transitions:
  - WAIT: s==0 stay; s==1 -> DECODE.
  - DECODE (no strobes):
    - 110/10 -> WRITE_IMM
    - 110/00 -> GET_B
    - 101/00, 101/01, 101/10 -> GET_A
    - 101/11 -> GET_B
    - any other encoding -> WAIT (no side effects)
  - WRITE_IMM: nsel=Rn, vsel=01, write=1 -> WAIT.
  - GET_A: nsel=Rn, loada=1 -> GET_B.
  - GET_B: nsel=Rm, loadb=1 -> next state by encoding:
    - 110/00 -> MOV_EXE
    - 101/01 -> CMP_EXE
    - otherwise -> ALU_EXE
  - ALU_EXE: loadc=1, asel=0 -> WRITE_REG.
  - MOV_EXE: loadc=1, asel=1 -> WRITE_REG.
  - CMP_EXE: loads=1, loadc=0 -> WAIT.
  - WRITE_REG: nsel=Rd, vsel=00, write=1 -> WAIT.
- Latency from the s-sampling edge to w high: MOV imm 3 edges; MVN/MOV reg 5; ADD/AND 6; CMP 5.
- s held high on return to WAIT starts the next instruction immediately (w high for exactly one cycle).
- Reset mid-instruction: the next edge returns to WAIT and suppresses any pending write/loads in that cycle.
- Status flags are not written by ADD/AND/MVN/MOV.

Decomposition:
- Package cpu_ctrl_pkg:
  - state enum (WAIT, DECODE, WRITE_IMM, GET_A, GET_B, ALU_EXE, MOV_EXE, CMP_EXE, WRITE_REG)
  - opcode/op constants (OPC_MOV=3'b110, OPC_ALU=3'b101, OP_ADD, OP_CMP, OP_AND, OP_MVN)
  - vsel encodings and nsel one-hot constants
- Sub-module instr_dec: combinational field extraction, sign extension, nsel->readnum/writenum mux.
- FSM and IR stay in cpu_controller.

Test Plan:
- Reset low 1 cycle, release -> w=1, write=0, loads=0, IR=0; s held 0 for 5 cycles -> state stays WAIT.
- in=16'hD204 (MOV R2,#4), load then s -> exactly one write pulse with writenum=2, vsel=01, sximm8=16'h0004; w returns high 3 edges after s sampled; in=16'hD2FF -> sximm8=16'hFFFF.
- in=16'hA06B (ADD R3,R0,R3,LSL#1):
  - readnum sequence 0 (loada), 3 (loadb), ALUop=00, loadc, then write with writenum=3, vsel=00.
  - 6 edges total.
- in=16'hA903 (CMP R1,R3): loads=1 for one cycle; write never asserted; w high after 5 edges.
- in=16'hBB43 (MVN R2,R3,...): no loada; ALUop=11. in=16'hC0A2 (MOV R5,R2): asel=1 during loadc; write to R5.
- Illegal in=16'hE000 -> DECODE then WAIT, no strobes. Reset asserted during GET_B of ADD -> WAIT next edge, write never asserted. load during busy -> IR unchanged.
